fcvt_f2i_pipe: RTL and testbench
================================

Name: fcvt_f2i_pipe

Overview:
- Two-stage pipelined FCVT.W.S / FCVT.WU.S execution stage inside the FPU fcvt cluster.
- Accepts a single-precision operand from FPU issue and resolves dynamic rounding (rm=DYN reads frm).
- Performs alignment, rounding, saturation and RISC-V exception-flag generation.
- Delivers an integer result plus fflags to integer writeback over a valid/ready handshake.

Parameters:
- XLEN, 32, integer result width; only 32 supported.
- TAG_W, 5, width of the opaque destination tag (rd index) carried alongside the data.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill; clears all valid bits
- in_valid  in  1  operand valid
- in_ready  out  1  stage can accept an operand
- in_op  in  32  IEEE-754 single operand
- in_rm  in  3  instruction rm field
- in_unsigned  in  1  1=FCVT.WU.S, 0=FCVT.W.S
- in_tag  in  TAG_W  destination tag
- frm_csr  in  3  fcsr.frm, sampled when an operand is accepted
- out_valid  out  1  result valid
- out_ready  in  1  writeback accepts
- out_result  out  32  integer result
- out_fflags  out  5  {NV,DZ,OF,UF,NX}; DZ/OF/UF are always 0
- out_illegal  out  1  rm resolved to a reserved value (101/110/111)
- out_tag  out  TAG_W  tag echoed

Behaviour:
- Reset (async, reset_n=0): both stage valid bits 0. Outputs reset as follows:
  - out_valid=0, out_result=0, out_fflags=0, out_illegal=0, out_tag=0.
  - in_ready=1 one cycle after reset deasserts.
- Handshake:
  - Transfer on valid&&ready, both sides.
  - in_ready = !s1_valid || s1_adv.
  - s1_adv = !s2_valid || out_ready.
  - Outputs remain stable while out_valid && !out_ready.
- Latency: 2 cycles from accept to out_valid with no backpressure; throughput 1 op/cycle.
- S1 (register stage):
  - Capture in_op, in_unsigned, in_tag.
  - Resolve rm: in_rm==111 → frm_csr, else in_rm.
  - Decode sign, biased exponent, mantissa with hidden bit (0 for exp==0), and classes: isNaN, isInf, isZero.
- S2 (compute, registered into output):
  - Unbiased e = exp-127.
  - e<0: the value is shifted fully into fraction bits; guard/round/sticky are derived from the shifted-out bits.
  - 0≤e≤31: left-align into a 55-bit fixed-point word.
  - e>31: overflow.
- Rounding:
  - RNE: +1 iff G&&(R||S||lsb).
  - RTZ: truncate.
  - RDN: +1 iff sign&&(G||R||S).
  - RUP: +1 iff !sign&&(G||R||S).
  - RMM: +1 iff G.
  - Increment is done on a 33-bit magnitude so carry-out is visible.
  - Signed result = sign ? -mag : mag.
- Range check on the rounded magnitude:
  - Signed: valid iff mag≤0x7FFFFFFF (positive) or mag≤0x80000000 (negative).
  - Unsigned: valid iff positive && mag≤0xFFFFFFFF, or mag==0.
- Invalid (NV=1, NX=0):
  - NaN or out-of-range positive/+Inf → 0x7FFFFFFF (signed) or 0xFFFFFFFF (unsigned).
  - Out-of-range negative/-Inf → 0x80000000 (signed) or 0x00000000 (unsigned).
  - NaN sign is ignored.
- NX = (G||R||S) && !NV.
- Zero and subnormal inputs: result 0; NX=1 for nonzero subnormals.
- Reserved resolved rm (101/110/111):
  - out_illegal=1, out_result=0, out_fflags=0.
  - Still flows through the pipe with normal latency.
- flush: same-cycle in_valid is ignored; S1/S2 valid cleared next edge; in-flight data discarded.
- Simultaneous flush and out_ready: flush wins, with no duplicate delivery.
- reset_n assertion mid-operation: immediate clear, with no partial result emitted.

Optional Feature:
- Macro FCVT_F2I_SKID_EN.
- Defined:
  - Adds a one-entry skid buffer on the output.
  - in_ready depends only on registered state (no combinational out_ready→in_ready path).
  - Latency unchanged; up to 3 ops in flight.
  - Skid drains before S2 presents new data; ordering is preserved.
- Undefined: no skid buffer; in_ready follows the combinational chain above.

Decomposition:
- Package fpu_cvt_pkg holds:
  - rm encodings RNE=000, RTZ=001, RDN=010, RUP=011, RMM=100, DYN=111.
  - fflags bit indices.
  - Saturation constants INT32_MAX/INT32_MIN/UINT32_MAX.
  - Struct f2i_s1_t (sign, exp, mant, class bits, rm, unsigned, tag).
- Sub-module fcvt_f2i_round: combinational shift/round/saturate/flags, instantiated between S1 and S2 registers.

Test Plan:
- 0x40200000 (2.5), signed, rm=RNE, out_ready=1 → out_result=2, fflags=0x01, out_valid exactly 2 cycles after accept.
- 0x40600000 (3.5): RNE → 4, RDN → 3.
- 0xC0600000 (-3.5): RDN → 0xFFFFFFFC (-4), NX.
- rm=111 with frm_csr=001, 0x3FE00000 (1.75) → 1, NX.
- Same with frm_csr=101 → out_illegal=1, result 0, fflags 0.
- Edge values:
  - 0x4F000000 signed → 0x7FFFFFFF, NV (0x10).
  - 0xCF000000 signed → 0x80000000, fflags 0.
  - 0x7FC00000 unsigned → 0xFFFFFFFF, NV.
  - 0xBF800000 unsigned → 0, NV.
  - 0xBE800000 (-0.25) unsigned RTZ → 0, NX only.
- Stream 4 back-to-back ops; hold out_ready=0 for 3 cycles → in_ready drops within 2 accepts (3 with skid), no loss/duplication, tags emerge in order.
- Flush asserted with S1 and S2 both full → out_valid=0 next cycle, next accepted op emerges 2 cycles later.
- reset_n pulsed mid-stream → outputs 0 immediately.

Source files
------------

// File: rtl/fpu_cvt_pkg.sv
// fpu_cvt_pkg: shared encodings, constants and stage bundles
// for the FPU float/int convert cluster.
package fpu_cvt_pkg;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;
    localparam logic [2:0] RM_DYN = 3'b111;

    localparam int FF_NV = 4;
    localparam int FF_DZ = 3;
    localparam int FF_OF = 2;
    localparam int FF_UF = 1;
    localparam int FF_NX = 0;

    localparam logic [31:0] INT32_MAX  = 32'h7FFF_FFFF;
    localparam logic [31:0] INT32_MIN  = 32'h8000_0000;
    localparam logic [31:0] UINT32_MAX = 32'hFFFF_FFFF;

    // Decoded operand held in S1; the tag travels beside it
    // because its width is a parameter of the stage.
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] mant;
        logic        is_nan;
        logic        is_inf;
        logic        is_zero;
        logic [2:0]  rm;
        logic        uns;
    } f2i_s1_t;

endpackage

// File: rtl/fcvt_f2i_round.sv
// fcvt_f2i_round: combinational align, round, saturate and
// fflags generation for single -> 32-bit integer conversion.
module fcvt_f2i_round
    import fpu_cvt_pkg::*;
(
    input  f2i_s1_t     op,
    output logic [31:0] result,
    output logic [4:0]  fflags,
    output logic        illegal
);

    logic [54:0] wide;
    logic [47:0] frac;
    logic [31:0] mag;
    logic [32:0] rmag;
    logic        g, r, s, ovf, inc, in_range, nv;

    // Align the significand: integer part plus guard/round/sticky
    always_comb begin
        wide = '0;
        frac = '0;
        mag  = '0;
        g    = 1'b0;
        r    = 1'b0;
        s    = 1'b0;
        ovf  = 1'b0;
        if (op.exp == 8'd0) begin
            s = !op.is_zero;
        end else if (op.exp < 8'd102) begin
            s = 1'b1;
        end else if (op.exp < 8'd127) begin
            frac = {op.mant, 24'd0} >> 5'(8'd126 - op.exp);
            g    = frac[47];
            r    = frac[46];
            s    = |frac[45:0];
        end else if (op.exp < 8'd159) begin
            wide = {31'd0, op.mant} << 5'(op.exp - 8'd127);
            mag  = wide[54:23];
            g    = wide[22];
            r    = wide[21];
            s    = |wide[20:0];
        end else begin
            ovf = 1'b1;
        end
    end

    // Rounding increment; zero/subnormal inputs always yield 0
    always_comb begin
        inc = 1'b0;
        unique case (op.rm)
            RM_RNE:  inc = g && (r || s || mag[0]);
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = op.sign && (g || r || s);
            RM_RUP:  inc = !op.sign && (g || r || s);
            RM_RMM:  inc = g;
            default: inc = 1'b0;
        endcase
        if (op.exp == 8'd0) inc = 1'b0;
        rmag = {1'b0, mag} + {32'd0, inc};
    end

    // Range check, saturation and exception flags
    always_comb begin
        illegal = op.rm > RM_RMM;
        if (op.uns)
            in_range = (!op.sign && !rmag[32]) || (rmag == 33'd0);
        else if (op.sign)
            in_range = rmag <= 33'h0_8000_0000;
        else
            in_range = rmag <= 33'h0_7FFF_FFFF;
        nv = op.is_nan || op.is_inf || ovf || !in_range;
        fflags = '0;
        if (illegal) begin
            result = '0;
        end else if (nv) begin
            fflags[FF_NV] = 1'b1;
            if (op.is_nan || !op.sign)
                result = op.uns ? UINT32_MAX : INT32_MAX;
            else
                result = op.uns ? 32'd0 : INT32_MIN;
        end else begin
            fflags[FF_NX] = g || r || s;
            result = (!op.uns && op.sign) ? -rmag[31:0] : rmag[31:0];
        end
    end

endmodule

// File: rtl/fcvt_f2i_pipe.sv
// fcvt_f2i_pipe: two-stage FCVT.W.S / FCVT.WU.S execution stage.
// FCVT_F2I_SKID_EN adds an output skid entry and a registered in_ready.
module fcvt_f2i_pipe
    import fpu_cvt_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_op,
    input  logic [2:0]       in_rm,
    input  logic             in_unsigned,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [2:0]       frm_csr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [4:0]       out_fflags,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    logic             live;
    logic             s1_valid;
    logic             s1_adv;
    logic [TAG_W-1:0] s1_tag;
    f2i_s1_t          s1_d;
    f2i_s1_t          s1_q;
    logic [31:0]      r_result;
    logic [4:0]       r_fflags;
    logic             r_illegal;

    // Decode the operand and resolve the dynamic rounding mode
    always_comb begin
        s1_d         = '0;
        s1_d.sign    = in_op[31];
        s1_d.exp     = in_op[30:23];
        s1_d.mant    = {|in_op[30:23], in_op[22:0]};
        s1_d.is_nan  = (&in_op[30:23]) && (|in_op[22:0]);
        s1_d.is_inf  = (&in_op[30:23]) && !(|in_op[22:0]);
        s1_d.is_zero = !(|in_op[30:0]);
        s1_d.rm      = (in_rm == RM_DYN) ? frm_csr : in_rm;
        s1_d.uns     = in_unsigned;
    end

    // S1: capture accepted operands; ready comes up a cycle after reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            live     <= 1'b0;
            s1_valid <= 1'b0;
            s1_q     <= '0;
            s1_tag   <= '0;
        end else begin
            live <= 1'b1;
            if (flush)
                s1_valid <= 1'b0;
            else if (in_ready)
                s1_valid <= in_valid;
            if (in_valid && in_ready) begin
                s1_q   <= s1_d;
                s1_tag <= in_tag;
            end
        end
    end

    fcvt_f2i_round u_round (
        .op      (s1_q),
        .result  (r_result),
        .fflags  (r_fflags),
        .illegal (r_illegal)
    );

`ifdef FCVT_F2I_SKID_EN
    logic             skid_valid;
    logic [XLEN-1:0]  skid_result;
    logic [4:0]       skid_fflags;
    logic             skid_illegal;
    logic [TAG_W-1:0] skid_tag;
    logic             push;
    logic             pop;

    assign s1_adv   = !skid_valid;
    assign in_ready = live && (!s1_valid || !skid_valid);
    assign push     = s1_valid && s1_adv;
    assign pop      = out_valid && out_ready;

    // Output queue: S2 registers are the head, the skid entry the tail
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_fflags   <= '0;
            out_illegal  <= 1'b0;
            out_tag      <= '0;
            skid_valid   <= 1'b0;
            skid_result  <= '0;
            skid_fflags  <= '0;
            skid_illegal <= 1'b0;
            skid_tag     <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (push && (pop || !out_valid)) begin
            out_valid   <= 1'b1;
            out_result  <= r_result;
            out_fflags  <= r_fflags;
            out_illegal <= r_illegal;
            out_tag     <= s1_tag;
        end else if (push) begin
            skid_valid   <= 1'b1;
            skid_result  <= r_result;
            skid_fflags  <= r_fflags;
            skid_illegal <= r_illegal;
            skid_tag     <= s1_tag;
        end else if (pop) begin
            out_valid  <= skid_valid;
            skid_valid <= 1'b0;
            if (skid_valid) begin
                out_result  <= skid_result;
                out_fflags  <= skid_fflags;
                out_illegal <= skid_illegal;
                out_tag     <= skid_tag;
            end
        end
    end
`else
    assign s1_adv   = !out_valid || out_ready;
    assign in_ready = live && (!s1_valid || s1_adv);

    // S2: register the rounded result until writeback takes it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_fflags  <= '0;
            out_illegal <= 1'b0;
            out_tag     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (s1_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_result  <= r_result;
                out_fflags  <= r_fflags;
                out_illegal <= r_illegal;
                out_tag     <= s1_tag;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fcvt_f2i_pipe.sv
// tb_fcvt_f2i_pipe: directed self-checking bench for fcvt_f2i_pipe.
// Each task drives one scenario and checks it against hand values.
module tb_fcvt_f2i_pipe;

    localparam logic [2:0] RNE = 3'b000;
    localparam logic [2:0] RTZ = 3'b001;
    localparam logic [2:0] RDN = 3'b010;
    localparam logic [2:0] RUP = 3'b011;
    localparam logic [2:0] RMM = 3'b100;
    localparam logic [2:0] DYN = 3'b111;

    typedef struct packed {
        logic [31:0] op;
        logic [2:0]  rm;
        logic        uns;
        logic [31:0] res;
        logic [4:0]  ff;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_op = '0;
    logic [2:0]  in_rm = '0;
    logic        in_unsigned = 1'b0;
    logic [4:0]  in_tag = '0;
    logic [2:0]  frm_csr = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [4:0]  out_fflags;
    logic        out_illegal;
    logic [4:0]  out_tag;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fcvt_f2i_pipe #(.XLEN(32), .TAG_W(5)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_rm       (in_rm),
        .in_unsigned (in_unsigned),
        .in_tag      (in_tag),
        .frm_csr     (frm_csr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_fflags  (out_fflags),
        .out_illegal (out_illegal),
        .out_tag     (out_tag)
    );

    // Issue one op, wait (bounded) for it, return output and latency.
    task automatic do_op(input logic [31:0] op, input logic [2:0] rm,
                         input logic uns, input logic [2:0] frm,
                         input logic [4:0] tag,
                         output logic [31:0] res, output logic [4:0] ff,
                         output logic ill, output logic [4:0] otag,
                         output int lat);
        int n;
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        in_op       = op;
        in_rm       = rm;
        in_unsigned = uns;
        frm_csr     = frm;
        in_tag      = tag;
        #1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        frm_csr  = 3'b000;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        res  = out_result;
        ff   = out_fflags;
        ill  = out_illegal;
        otag = out_tag;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_result, out_fflags, out_illegal, out_tag} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b r=%h f=%h i=%b t=%h expected all 0",
                     out_valid, out_result, out_fflags, out_illegal, out_tag);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_round();
        logic [31:0] r;
        logic [4:0]  f, t;
        logic        il;
        int          lat;
        do_op(32'h40200000, RNE, 1'b0, 3'd0, 5'd1, r, f, il, t, lat);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL latency_2p5: got %0d expected 2", lat);
        end
        checks++;
        if ({il, f, r, t} !== {1'b0, 5'h01, 32'd2, 5'd1}) begin
            errors++;
            $display("FAIL rne_2p5: got i=%b f=%h r=%h t=%h expected 0/01/00000002/01", il, f, r, t);
        end
        do_op(32'h40600000, RNE, 1'b0, 3'd0, 5'd2, r, f, il, t, lat);
        checks++;
        if ({il, f, r} !== {1'b0, 5'h01, 32'd4}) begin
            errors++;
            $display("FAIL rne_3p5: got i=%b f=%h r=%h expected 0/01/00000004", il, f, r);
        end
        do_op(32'h40600000, RDN, 1'b0, 3'd0, 5'd3, r, f, il, t, lat);
        checks++;
        if ({il, f, r} !== {1'b0, 5'h01, 32'd3}) begin
            errors++;
            $display("FAIL rdn_3p5: got i=%b f=%h r=%h expected 0/01/00000003", il, f, r);
        end
        do_op(32'hC0600000, RDN, 1'b0, 3'd0, 5'd4, r, f, il, t, lat);
        checks++;
        if ({il, f, r} !== {1'b0, 5'h01, 32'hFFFFFFFC}) begin
            errors++;
            $display("FAIL rdn_m3p5: got i=%b f=%h r=%h expected 0/01/fffffffc", il, f, r);
        end
    endtask

    task automatic test_dyn_rm();
        logic [31:0] r;
        logic [4:0]  f, t;
        logic        il;
        int          lat;
        do_op(32'h3FE00000, DYN, 1'b0, 3'b001, 5'd5, r, f, il, t, lat);
        checks++;
        if ({il, f, r} !== {1'b0, 5'h01, 32'd1}) begin
            errors++;
            $display("FAIL dyn_rtz: got i=%b f=%h r=%h expected 0/01/00000001", il, f, r);
        end
        do_op(32'h3FE00000, DYN, 1'b0, 3'b101, 5'd6, r, f, il, t, lat);
        checks++;
        if ({il, f, r, t} !== {1'b1, 5'h00, 32'd0, 5'd6}) begin
            errors++;
            $display("FAIL dyn_reserved: got i=%b f=%h r=%h t=%h expected 1/00/00000000/06", il, f, r, t);
        end
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL latency_reserved: got %0d expected 2", lat);
        end
    endtask

    task automatic test_edges();
        vec_t        v [12];
        logic [31:0] r;
        logic [4:0]  f, t;
        logic        il;
        int          lat;
        v[0]  = '{32'h4F000000, RTZ, 1'b0, 32'h7FFFFFFF, 5'h10};
        v[1]  = '{32'hCF000000, RTZ, 1'b0, 32'h80000000, 5'h00};
        v[2]  = '{32'h7FC00000, RTZ, 1'b1, 32'hFFFFFFFF, 5'h10};
        v[3]  = '{32'hBF800000, RTZ, 1'b1, 32'h00000000, 5'h10};
        v[4]  = '{32'hBE800000, RTZ, 1'b1, 32'h00000000, 5'h01};
        v[5]  = '{32'hFF800000, RNE, 1'b0, 32'h80000000, 5'h10};
        v[6]  = '{32'h4F800000, RTZ, 1'b1, 32'hFFFFFFFF, 5'h10};
        v[7]  = '{32'h4F7FFFFF, RTZ, 1'b1, 32'hFFFFFF00, 5'h00};
        v[8]  = '{32'h00000001, RUP, 1'b0, 32'h00000000, 5'h01};
        v[9]  = '{32'hFFC00000, RTZ, 1'b0, 32'h7FFFFFFF, 5'h10};
        v[10] = '{32'h3F000000, RMM, 1'b0, 32'h00000001, 5'h01};
        v[11] = '{32'hCF000001, RTZ, 1'b0, 32'h80000000, 5'h10};
        for (int i = 0; i < 12; i++) begin
            do_op(v[i].op, v[i].rm, v[i].uns, 3'd0, 5'(i), r, f, il, t, lat);
            checks++;
            if ({il, f, r} !== {1'b0, v[i].ff, v[i].res}) begin
                errors++;
                $display("FAIL edge_%0d op=%h: got i=%b f=%h r=%h expected 0/%h/%h",
                         i, v[i].op, il, f, r, v[i].ff, v[i].res);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ops [4];
        logic [4:0]  rtag [4];
        logic [31:0] rres [4];
        int idx, nrecv, stall_acc, extra, exp_acc;
        ops = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        idx = 0;
        nrecv = 0;
        stall_acc = 0;
        in_rm = RTZ;
        in_unsigned = 1'b0;
        frm_csr = 3'd0;
        for (int c = 0; c < 40 && nrecv < 4; c++) begin
            out_ready = (c >= 3);
            in_valid  = (idx < 4);
            if (idx < 4) in_op = ops[idx];
            in_tag = 5'(idx + 1);
            #1;
            if (in_valid && in_ready) begin
                if (c < 3) stall_acc++;
                idx++;
            end
            if (out_valid && out_ready) begin
                if (nrecv < 4) begin
                    rtag[nrecv] = out_tag;
                    rres[nrecv] = out_result;
                end
                nrecv++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        extra = 0;
        repeat (4) begin
            if (out_valid) extra++;
            @(posedge clk); #1;
        end
`ifdef FCVT_F2I_SKID_EN
        exp_acc = 3;
`else
        exp_acc = 2;
`endif
        checks++;
        if (stall_acc !== exp_acc) begin
            errors++;
            $display("FAIL b2b_stall_accepts: got %0d expected %0d", stall_acc, exp_acc);
        end
        checks++;
        if (nrecv !== 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected 4", nrecv);
        end
        for (int i = 0; i < 4 && i < nrecv; i++) begin
            checks++;
            if (rtag[i] !== 5'(i + 1) || rres[i] !== 32'(i + 1)) begin
                errors++;
                $display("FAIL b2b_order_%0d: got t=%h r=%h expected t=%h r=%h",
                         i, rtag[i], rres[i], 5'(i + 1), 32'(i + 1));
            end
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL b2b_duplicate: got %0d extra outputs expected 0", extra);
        end
    endtask

    task automatic test_flush();
        logic [31:0] r;
        logic [4:0]  f, t;
        logic        il;
        int          lat;
        out_ready = 1'b0;
        in_rm = RTZ;
        in_unsigned = 1'b0;
        in_valid = 1'b1;
        in_op = 32'h3F800000;
        in_tag = 5'd5;
        @(posedge clk); #1;
        in_op = 32'h40000000;
        in_tag = 5'd6;
        @(posedge clk); #1;
        checks++;
        if ({out_valid, out_tag, out_result} !== {1'b1, 5'd5, 32'd1}) begin
            errors++;
            $display("FAIL flush_fill: got v=%b t=%h r=%h expected 1/05/00000001",
                     out_valid, out_tag, out_result);
        end
        flush = 1'b1;
        in_op = 32'h40400000;
        in_tag = 5'd7;
        out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear: got out_valid=%b expected 0", out_valid);
        end
        do_op(32'h40A00000, RTZ, 1'b0, 3'd0, 5'd9, r, f, il, t, lat);
        checks++;
        if (lat !== 2 || {t, r, f} !== {5'd9, 32'd5, 5'h00}) begin
            errors++;
            $display("FAIL flush_next: got lat=%0d t=%h r=%h f=%h expected 2/09/00000005/00",
                     lat, t, r, f);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        logic [4:0]  f, t;
        logic        il;
        int          lat;
        out_ready = 1'b0;
        in_rm = RTZ;
        in_unsigned = 1'b0;
        in_valid = 1'b1;
        in_op = 32'h3F800000;
        in_tag = 5'd3;
        @(posedge clk); #1;
        in_op = 32'h40000000;
        in_tag = 5'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_result} !== {1'b1, 32'd1}) begin
            errors++;
            $display("FAIL rstmid_pre: got v=%b r=%h expected 1/00000001", out_valid, out_result);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_result, out_fflags, out_illegal, out_tag} !== '0) begin
            errors++;
            $display("FAIL rstmid_clear: got v=%b r=%h f=%h i=%b t=%h expected all 0",
                     out_valid, out_result, out_fflags, out_illegal, out_tag);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL rstmid_after: got v=%b rdy=%b expected 0/1", out_valid, in_ready);
        end
        do_op(32'h40400000, RNE, 1'b1, 3'd0, 5'd12, r, f, il, t, lat);
        checks++;
        if (lat !== 2 || {t, r, f} !== {5'd12, 32'd3, 5'h00}) begin
            errors++;
            $display("FAIL rstmid_next: got lat=%0d t=%h r=%h f=%h expected 2/0c/00000003/00",
                     lat, t, r, f);
        end
    endtask

    initial begin
        test_reset();
        test_round();
        test_dyn_rm();
        test_edges();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
